// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA 640x480 timing and colour constants
// Used by vga_sync_gen and by the object/block controller that produces rgb.
// Contents: sync/visible-window boundaries on the hCount/vCount scale,
// 12-bit {R,G,B} colour constants, colour-bar lookup for the test pattern.
package vga_pkg;

  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BP_END  = 10'd144;
  localparam logic [9:0] H_VIS_END = 10'd783;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BP_END  = 10'd35;
  localparam logic [9:0] V_VIS_END = 10'd514;

  localparam logic [9:0] BAR_WIDTH = 10'd80;

  localparam logic [11:0] RED     = 12'hF00;
  localparam logic [11:0] GREEN   = 12'h0F0;
  localparam logic [11:0] BLUE    = 12'h00F;
  localparam logic [11:0] BLACK   = 12'h000;
  localparam logic [11:0] WHITE   = 12'hFFF;
  localparam logic [11:0] YELLOW  = 12'hFF0;
  localparam logic [11:0] CYAN    = 12'h0FF;
  localparam logic [11:0] MAGENTA = 12'hF0F;

  // Bars run left to right in classic SMPTE-like order.
  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    logic [11:0] c;
    case (idx)
      3'd0:    c = WHITE;
      3'd1:    c = YELLOW;
      3'd2:    c = CYAN;
      3'd3:    c = GREEN;
      3'd4:    c = MAGENTA;
      3'd5:    c = RED;
      3'd6:    c = BLUE;
      default: c = BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - video bundle between the sync generator and its users
// master: the sync generator (consumes rgb[/test_en], drives counters, syncs, DAC colour).
// slave : the block controller / pin side (drives rgb[/test_en], observes the rest).
// test_en only exists when VGA_TEST_PATTERN_EN is defined.
interface vga_sync_gen_if;
  logic [11:0] rgb;
`ifdef VGA_TEST_PATTERN_EN
  logic        test_en;
`endif
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        bright;
  logic        pix_tick;
  logic        frame_start;
  logic [15:0] frame_cnt;
  logic        hSync;
  logic        vSync;
  logic [3:0]  vgaR;
  logic [3:0]  vgaG;
  logic [3:0]  vgaB;

  modport master (
`ifdef VGA_TEST_PATTERN_EN
    input  test_en,
`endif
    input  rgb,
    output hCount, vCount, bright, pix_tick, frame_start, frame_cnt,
    output hSync, vSync, vgaR, vgaG, vgaB
  );

  modport slave (
`ifdef VGA_TEST_PATTERN_EN
    output test_en,
`endif
    output rgb,
    input  hCount, vCount, bright, pix_tick, frame_start, frame_cnt,
    input  hSync, vSync, vgaR, vgaG, vgaB
  );
endinterface

// File: rtl/clk_en_div.sv
// rtl/clk_en_div.sv - clock-enable divider producing one tick every DIV clocks
// Ports: clk (system clock), rst (sync, active-low), tick (high while count==DIV-1).
// DIV must be >= 2 so that tick is low while held in reset.
module clk_en_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Combinational so tick lines up with the last count, not one clk after it.
  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA 640x480 counter, sync and colour output stage
// Ports: clk (system clock), rst (sync, active-low),
//        vga (vga_sync_gen_if.master): rgb in; hCount/vCount, bright, pix_tick,
//        frame_start, frame_cnt, hSync/vSync (active-low), vgaR/G/B out.
// Optional: VGA_TEST_PATTERN_EN adds test_en, selecting 8 colour bars over rgb.
module vga_sync_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic           clk,
  input  logic           rst,
  vga_sync_gen_if.master vga
);

  import vga_pkg::*;

  logic        pix_tick;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [15:0] f_cnt;
  logic [3:0]  r_q;
  logic [3:0]  g_q;
  logic [3:0]  b_q;
  logic        hs_q;
  logic        vs_q;
  logic        h_last;
  logic        v_last;
  logic        frame_start;
  logic        bright;
  logic [11:0] pix_colour;

  clk_en_div #(.DIV(CLK_DIV)) u_clk_en_div (
    .clk  (clk),
    .rst  (rst),
    .tick (pix_tick)
  );

  assign h_last      = (h_cnt == 10'(H_TOTAL - 1));
  assign v_last      = (v_cnt == 10'(V_TOTAL - 1));
  assign frame_start = pix_tick && h_last && v_last;

  assign bright = (h_cnt >= H_BP_END) && (h_cnt <= H_VIS_END) &&
                  (v_cnt >= V_BP_END) && (v_cnt <= V_VIS_END);

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0] bar_off;
  // Offset is only meaningful inside the visible window; outside it the
  // colour is blanked anyway, so the wrapped value never reaches the pins.
  assign bar_off    = h_cnt - H_BP_END;
  assign pix_colour = vga.test_en ? bar_colour(3'(bar_off / BAR_WIDTH)) : vga.rgb;
`else
  assign pix_colour = vga.rgb;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
      f_cnt <= '0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (pix_tick) begin
      h_cnt <= h_last ? '0 : h_cnt + 10'd1;
      if (h_last) begin
        v_cnt <= v_last ? '0 : v_cnt + 10'd1;
      end
      if (frame_start) begin
        f_cnt <= f_cnt + 16'd1;
      end
      // Colour and sync are captured in the same stage so the DAC and the
      // sync pins stay aligned, both one pixel behind the counters.
      {r_q, g_q, b_q} <= bright ? pix_colour : BLACK;
      hs_q <= (h_cnt >= H_SYNC);
      vs_q <= (v_cnt >= V_SYNC);
    end
  end

  assign vga.hCount      = h_cnt;
  assign vga.vCount      = v_cnt;
  assign vga.bright      = bright;
  assign vga.pix_tick    = pix_tick;
  assign vga.frame_start = frame_start;
  assign vga.frame_cnt   = f_cnt;
  assign vga.hSync       = hs_q;
  assign vga.vSync       = vs_q;
  assign vga.vgaR        = r_q;
  assign vga.vgaG        = g_q;
  assign vga.vgaB        = b_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench for vga_sync_gen against an arithmetic timing model
module tb_vga_sync_gen;

  localparam int DIV_D = 4;
  localparam int HT_D  = 800;
  localparam int VT_D  = 525;
  localparam int DIV_S = 2;
  localparam int HT_S  = 800;
  localparam int VT_S  = 36;
  localparam int N_CYC = 63000;
  localparam int MID   = 60000;

  logic clk = 1'b0;
  logic rst;
  bit   ten_v;

  always #5 clk = ~clk;

  vga_sync_gen_if if_d ();
  vga_sync_gen_if if_s ();

  vga_sync_gen #(.CLK_DIV(DIV_D), .H_TOTAL(HT_D), .V_TOTAL(VT_D)) dut_d (
    .clk (clk),
    .rst (rst),
    .vga (if_d)
  );

  vga_sync_gen #(.CLK_DIV(DIV_S), .H_TOTAL(HT_S), .V_TOTAL(VT_S)) dut_s (
    .clk (clk),
    .rst (rst),
    .vga (if_s)
  );

  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        bright;
    logic        tick;
    logic        fs;
    logic [15:0] fc;
    logic        hs;
    logic        vs;
    logic [11:0] col;
  } obs_t;

  typedef struct {
    obs_t o;
    int   c;
    bit   mid;
  } exp_t;

  exp_t q_d[$];
  exp_t q_s[$];

  int checks   = 0;
  int failures = 0;
  int fs_total = 0;
  bit hs_done  = 0;
  bit vs_done  = 0;

  function automatic bit vis(input int h, input int v);
    return (h >= 144) && (h <= 783) && (v >= 35) && (v <= 514);
  endfunction

  function automatic logic [11:0] bar_ref(input int h);
    int b;
    b = (h - 144) / 80;
    case (b)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  // c counts clock edges since reset release; pixel k = c/div.
  function automatic void model_step(input int div, input int ht, input int vt,
                                     input bit rv, input logic [11:0] rgb_i, input bit ten,
                                     inout int c, inout logic [11:0] col,
                                     inout logic hs, inout logic vs);
    int k, hp, vp;
    if (!rv) begin
      c = 0; col = 12'h000; hs = 1'b1; vs = 1'b1;
      return;
    end
    if ((c % div) == div - 1) begin
      k  = c / div;
      hp = k % ht;
      vp = (k / ht) % vt;
      col = !vis(hp, vp) ? 12'h000 : (ten ? bar_ref(hp) : rgb_i);
      hs = (hp >= 96);
      vs = (vp >= 2);
    end
    c = c + 1;
  endfunction

  function automatic obs_t predict(input int div, input int ht, input int vt, input int c,
                                   input logic [11:0] col, input logic hs, input logic vs);
    obs_t o;
    int k, h, v;
    k = c / div;
    h = k % ht;
    v = (k / ht) % vt;
    o.h      = 10'(h);
    o.v      = 10'(v);
    o.bright = vis(h, v);
    o.tick   = ((c % div) == div - 1);
    o.fs     = o.tick && (h == ht - 1) && (v == vt - 1);
    o.fc     = 16'((k / (ht * vt)) % 65536);
    o.hs     = hs;
    o.vs     = vs;
    o.col    = col;
    return o;
  endfunction

  task automatic cmp(input string name, input obs_t a, input obs_t e, input int c);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s c=%0d actual h=%0d v=%0d br=%b tk=%b fs=%b fc=%0d hs=%b vs=%b col=%h required h=%0d v=%0d br=%b tk=%b fs=%b fc=%0d hs=%b vs=%b col=%h",
               name, c, a.h, a.v, a.bright, a.tick, a.fs, a.fc, a.hs, a.vs, a.col,
               e.h, e.v, e.bright, e.tick, e.fs, e.fc, e.hs, e.vs, e.col);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    obs_t a;
    obs_t pd;
    obs_t ps;
    bit   have_prev;
    int   hs_cnt;
    int   vs_cnt;
    have_prev = 0;
    hs_cnt = 0;
    vs_cnt = 0;
    pd = '0;
    ps = '0;
    forever begin
      @(negedge clk);
      if (q_d.size() > 0 && q_s.size() > 0) begin
        e = q_d.pop_front();
        a = '{if_d.hCount, if_d.vCount, if_d.bright, if_d.pix_tick, if_d.frame_start,
              if_d.frame_cnt, if_d.hSync, if_d.vSync, {if_d.vgaR, if_d.vgaG, if_d.vgaB}};
        cmp("model_default", a, e.o, e.c);
        if (e.c == 3) chk("release_tick_clk3", 32'(a.tick), 32'd1);
        if (e.c == 4) chk("release_h1_clk4", 32'(a.h), 32'd1);
        if (have_prev && pd.tick && pd.h == 10'd799 && pd.v == 10'd10) begin
          chk("line_wrap_h", 32'(a.h), 32'd0);
          chk("line_wrap_v", 32'(a.v), 32'd11);
        end
        if (!hs_done) begin
          if (a.v == 10'd5 && !a.hs) hs_cnt++;
          if (a.v == 10'd6) begin
            chk("hsync_low_clks", 32'(hs_cnt), 32'd384);
            hs_done = 1;
          end
        end
        pd = a;

        e = q_s.pop_front();
        a = '{if_s.hCount, if_s.vCount, if_s.bright, if_s.pix_tick, if_s.frame_start,
              if_s.frame_cnt, if_s.hSync, if_s.vSync, {if_s.vgaR, if_s.vgaG, if_s.vgaB}};
        cmp("model_small", a, e.o, e.c);
        if (e.mid) begin
          chk("mid_rst_h", 32'(a.h), 32'd0);
          chk("mid_rst_v", 32'(a.v), 32'd0);
          chk("mid_rst_col", 32'(a.col), 32'd0);
          chk("mid_rst_hs", 32'(a.hs), 32'd1);
          chk("mid_rst_vs", 32'(a.vs), 32'd1);
        end
        if (have_prev && ps.tick) begin
          if (ps.h == 10'd100) chk("blank_h100_r", 32'(a.col[11:8]), 32'd0);
          if (ps.h == 10'd144 && ps.v == 10'd35 && if_s.rgb == 12'hF00 && !ten_v)
            chk("vis_start_r", 32'(a.col[11:8]), 32'hF);
          if (ps.h == 10'd784 && ps.v == 10'd35) chk("vis_end_r", 32'(a.col[11:8]), 32'd0);
        end
        if (have_prev && ps.fs) begin
          chk("frame_wrap_h", 32'(a.h), 32'd0);
          chk("frame_wrap_v", 32'(a.v), 32'd0);
          chk("frame_wrap_cnt", 32'(a.fc), 32'(ps.fc) + 32'd1);
          chk("frame_start_width", 32'(a.fs), 32'd0);
        end
        if (a.fs) fs_total++;
        if (!vs_done) begin
          if (a.fs) begin
            chk("vsync_low_clks", 32'(vs_cnt), 32'd3200);
            vs_done = 1;
          end else if (!a.vs) begin
            vs_cnt++;
          end
        end
        ps = a;
        have_prev = 1;
      end
    end
  end

  initial begin : driver
    exp_t e;
    bit   rv;
    bit   tv;
    logic [11:0] rg;
    int   dc, sc;
    logic [11:0] dcol, scol;
    logic dhs, dvs, shs, svs;
    dc = 0; sc = 0; dcol = '0; scol = '0;
    dhs = 1'b1; dvs = 1'b1; shs = 1'b1; svs = 1'b1;
    rst = 1'b0;
    ten_v = 1'b0;
    if_d.rgb = '0;
    if_s.rgb = '0;
`ifdef VGA_TEST_PATTERN_EN
    if_d.test_en = 1'b0;
    if_s.test_en = 1'b0;
`endif
    for (int n = 0; n < N_CYC; n++) begin
      @(negedge clk);
      #1;
      rv = !(n < 4 || (n >= MID && n < MID + 2));
      rg = ($urandom_range(3) != 0) ? 12'hF00 : 12'($urandom);
      tv = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
      tv = (n >= 40000 && n < MID);
      if_d.test_en = tv;
      if_s.test_en = tv;
`endif
      ten_v = tv;
      rst = rv;
      if_d.rgb = rg;
      if_s.rgb = rg;

      model_step(DIV_D, HT_D, VT_D, rv, rg, tv, dc, dcol, dhs, dvs);
      e.o = predict(DIV_D, HT_D, VT_D, dc, dcol, dhs, dvs);
      e.c = dc;
      e.mid = (n == MID);
      q_d.push_back(e);

      model_step(DIV_S, HT_S, VT_S, rv, rg, tv, sc, scol, shs, svs);
      e.o = predict(DIV_S, HT_S, VT_S, sc, scol, shs, svs);
      e.c = sc;
      e.mid = (n == MID);
      q_s.push_back(e);
    end
    @(negedge clk);
    #2;
    chk("queues_drained", 32'(q_d.size() + q_s.size()), 32'd0);
    chk("hsync_window_seen", 32'(hs_done), 32'd1);
    chk("vsync_window_seen", 32'(vs_done), 32'd1);
    chk("frame_start_pulses", 32'(fs_total), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: system clocks per pixel (100 MHz to 25 MHz).
REQ-002 SHALL have parameter H_TOTAL, default 800: pixels per line. V_TOTAL, default 525: lines per frame.
REQ-003 SHALL have ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have ports:
- rgb, input, 12: pixel colour from the object/block controller, {R[3:0],G[3:0],B[3:0]}.
- hCount, output, 10: horizontal pixel counter.
- vCount, output, 10: vertical line counter.
- bright, output, 1: high inside the visible area.
- pix_tick, output, 1: one-clk pulse per pixel.
- frame_start, output, 1: one-clk pulse at frame wrap.
- frame_cnt, output, 16: frames since reset.
- hSync, output, 1: horizontal sync, active-low.
- vSync, output, 1: vertical sync, active-low.
- vgaR, vgaG, vgaB, output, 4 each: registered colour to the DAC pins.

Function
REQ-005 SHALL hold a divider counter 0..CLK_DIV-1 that wraps to 0; pix_tick is high exactly in the clk where divider==CLK_DIV-1.
REQ-006 SHALL advance hCount by 1 only on pix_tick; at H_TOTAL-1 (799) it wraps to 0 and vCount advances.
REQ-007 SHALL wrap vCount from V_TOTAL-1 (524) to 0 on the same pix_tick as the hCount wrap.
REQ-008 SHALL drive bright combinationally from the counters: 144<=hCount<=783 and 35<=vCount<=514 (640x480 visible).
REQ-009 SHALL compute raw sync from the counters: hSync_raw low for hCount<96, vSync_raw low for vCount<2.
REQ-010 SHALL sample rgb on pix_tick into vgaR/G/B, forced to 0 when bright is low.
REQ-011 SHALL register hSync/vSync on pix_tick in the same stage as the colour, so sync and colour share one pixel of latency.
REQ-012 SHALL pulse frame_start for one clk on the pix_tick where the counters move (799,524)->(0,0).
REQ-013 SHALL increment frame_cnt on frame_start and wrap from 0xFFFF to 0.
REQ-014 SHALL keep hCount/vCount stable between pix_ticks, so downstream logic on clk sees one value for CLK_DIV clks.

Reset
REQ-015 SHALL set the following when rst is low at a clk edge: divider=0, hCount=0, vCount=0, frame_cnt=0, pix_tick=0, frame_start=0, vgaR/G/B=0, hSync=1, vSync=1.
REQ-016 SHALL restart mid-frame resets from (0,0); the first pix_tick comes CLK_DIV clks after release.

Configuration
REQ-017 SHALL, with VGA_TEST_PATTERN_EN defined, add input test_en (1 bit). When test_en=1, 8 vertical colour bars of 80 pixels each replace rgb: white, yellow, cyan, green, magenta, red, blue, black.
REQ-018 SHALL, without VGA_TEST_PATTERN_EN, have no test_en port and always use rgb.

Structure
REQ-019 SHALL place the following in shared package vga_pkg for reuse by the block controller:
- timing constants: H_SYNC=96, H_BP_END=144, H_VIS_END=783, V_SYNC=2, V_BP_END=35, V_VIS_END=514;
- colour constants RED/GREEN/BLACK/WHITE.
REQ-020 SHALL implement the pixel-tick divider as sub-module clk_en_div.

Verification
REQ-021 SHALL test reset release: rst high from cycle 0 -> pix_tick at clk 3; hCount 0->1 at clk 4.
REQ-022 SHALL test line wrap: hCount=799, vCount=10 -> next pix_tick gives hCount=0, vCount=11.
REQ-023 SHALL test frame wrap: (799,524) -> (0,0), frame_start high exactly 1 clk, frame_cnt 0->1.
REQ-024 SHALL test sync widths: hSync low 96 pixels (384 clk) per line; vSync low 1600 pixels per frame.
REQ-025 SHALL test blanking: rgb=12'hF00.
- At hCount=100 -> vgaR=0.
- At (144,35) -> vgaR=4'hF one pixel later.
- At (784,35) -> vgaR=0 one pixel later.
REQ-026 SHALL test mid-frame reset: rst low at (400,300) -> next clk hCount=0, vCount=0, vga*=0, hSync=vSync=1.
